// File: rtl/pool_window_sequencer_pkg.sv
// Shared definitions for the pooling window sequencer.
//   state_e      : sequencer state encoding
//   CB_*         : bit positions inside a row's 4-bit ALU control nibble
//   KSIZE_*      : window-size codes as presented on kSize
package pool_window_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACC,
        ST_EMIT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int unsigned CB_WR  = 3;
    localparam int unsigned CB_UP  = 2;
    localparam int unsigned CB_CUR = 1;
    localparam int unsigned CB_LOW = 0;

    localparam logic [1:0] KSIZE_ILLEGAL = 2'd0;
    localparam logic [1:0] KSIZE_1       = 2'd1;
    localparam logic [1:0] KSIZE_2       = 2'd2;
    localparam logic [1:0] KSIZE_3       = 2'd3;

endpackage

// File: rtl/pool_window_sequencer_if.sv
// Handshake/bus bundle between the line buffer / writeback side and the
// pooling sequencer.
//   master : drives start, kSize, numCols, colValid, outReady
//   slave  : the sequencer; drives colReady, controlBus, outValid,
//            outRowMask, busy, done, cfgErr
interface pool_window_sequencer_if #(
    parameter int N  = 8,
    parameter int CW = 10
);
    logic           start;
    logic [1:0]     kSize;
    logic [CW-1:0]  numCols;
    logic           colValid;
    logic           colReady;
    logic [4*N-1:0] controlBus;
    logic           outValid;
    logic           outReady;
    logic [N-1:0]   outRowMask;
    logic           busy;
    logic           done;
    logic           cfgErr;

    modport master (
        output start, kSize, numCols, colValid, outReady,
        input  colReady, controlBus, outValid, outRowMask, busy, done, cfgErr
    );

    modport slave (
        input  start, kSize, numCols, colValid, outReady,
        output colReady, controlBus, outValid, outRowMask, busy, done, cfgErr
    );
endinterface

// File: rtl/pool_window_sequencer_row_mask_gen.sv
// Combinational row decode for a KxK pooling column.
//   k_size      in  : window size code (0 gives an empty mask)
//   active_mask out : rows that hold a window centre / result
//   use_bits    out : per-row nibble {0, useUpper, useCurrent, useLower}
// Neighbour taps that would fall off the column ends are suppressed; the
// ALU then treats them as zero, which is harmless for non-negative data.
module pool_row_mask_gen
    import pool_window_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]     k_size,
    output logic [N-1:0]   active_mask,
    output logic [4*N-1:0] use_bits
);

    for (genvar i = 0; i < N; i++) begin : g_row
        logic act;
        logic up;
        logic cur;
        logic low;

        always_comb begin
            act = 1'b0;
            up  = 1'b0;
            cur = 1'b0;
            low = 1'b0;
            case (k_size)
                KSIZE_1: begin
                    act = 1'b1;
                    cur = 1'b1;
                end
                KSIZE_2: begin
                    if (i % 2 == 0) begin
                        act = 1'b1;
                        cur = 1'b1;
                        low = 1'b1;
                    end
                end
                KSIZE_3: begin
                    if (i % 3 == 1) begin
                        act = 1'b1;
                        up  = 1'b1;
                        cur = 1'b1;
                        low = 1'b1;
                    end else if ((i == N - 1) && (N % 3 == 1)) begin
                        // lone trailing row forms its own 1-row window
                        act = 1'b1;
                        cur = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        assign active_mask[i]   = act;
        assign use_bits[4*i+3]  = 1'b0;
        assign use_bits[4*i+2]  = up & (i != 0);
        assign use_bits[4*i+1]  = cur;
        assign use_bits[4*i+0]  = low & (i != N - 1);
    end

endmodule

// File: rtl/pool_window_sequencer.sv
// Pooling window sequencer: runs clear -> accumulate -> emit for each
// non-overlapping KxK window and drives the control nibbles of N ALU rows.
//   CLK, RSTn : rising-edge clock, asynchronous active-low reset
//   bus       : slave side of pool_window_sequencer_if
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | active rows zero their max register (1 cycle)
// ACC   | consume K columns into the running max
// EMIT  | results held in the ALUs until writeback takes them
// DRAIN | swallow the numCols mod K leftover columns
// DONE  | one-cycle done pulse, then IDLE
module pool_window_sequencer
    import pool_window_sequencer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 10
) (
    input  logic CLK,
    input  logic RSTn,
    pool_window_sequencer_if.slave bus
);

    state_e         state_q,     state_d;
    logic [1:0]     k_q,         k_d;
    logic [CW-1:0]  num_cols_q,  num_cols_d;
    logic [CW-1:0]  col_cnt_q,   col_cnt_d;
    logic [1:0]     win_col_q,   win_col_d;
    logic [N-1:0]   active_q,    active_d;
    logic [4*N-1:0] use_q,       use_d;
    logic [4*N-1:0] ctrl_q,      ctrl_d;
    logic           col_ready_q, col_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_mask_q,  out_mask_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic           cfg_err_q,   cfg_err_d;

    logic [N-1:0]   gen_active;
    logic [4*N-1:0] gen_use;
    logic [4*N-1:0] clear_word;
    logic [4*N-1:0] acc_word;
    logic [CW-1:0]  remaining;
    logic [CW-1:0]  k_ext;
    logic           col_fire;

    pool_row_mask_gen #(.N(N)) u_mask_gen (
        .k_size      (bus.kSize),
        .active_mask (gen_active),
        .use_bits    (gen_use)
    );

    for (genvar i = 0; i < N; i++) begin : g_word
        assign clear_word[4*i +: 4] = {active_d[i], 3'b000};
        assign acc_word[4*i +: 4]   = {active_q[i], use_q[4*i+CB_UP],
                                       use_q[4*i+CB_CUR], use_q[4*i+CB_LOW]};
    end

    assign col_fire  = bus.colValid & col_ready_q;
    assign remaining = num_cols_q - col_cnt_q;
    assign k_ext     = {{(CW-2){1'b0}}, k_q};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        num_cols_d = num_cols_q;
        col_cnt_d  = col_cnt_q;
        win_col_d  = win_col_q;
        active_d   = active_q;
        use_d      = use_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.kSize == KSIZE_ILLEGAL) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        k_d        = bus.kSize;
                        num_cols_d = bus.numCols;
                        col_cnt_d  = '0;
                        win_col_d  = '0;
                        active_d   = gen_active;
                        use_d      = gen_use;
                        if (bus.numCols == '0)
                            state_d = ST_DONE;
                        else if (bus.numCols < {{(CW-2){1'b0}}, bus.kSize})
                            state_d = ST_DRAIN;
                        else
                            state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: state_d = ST_ACC;
            ST_ACC: begin
                if (col_fire) begin
                    col_cnt_d = col_cnt_q + CW'(1);
                    if (win_col_q + 2'd1 == k_q) begin
                        win_col_d = '0;
                        state_d   = ST_EMIT;
                    end else begin
                        win_col_d = win_col_q + 2'd1;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.outReady) begin
                    if (remaining == '0)
                        state_d = ST_DONE;
                    else if (remaining >= k_ext)
                        state_d = ST_CLEAR;
                    else
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (col_fire) begin
                    col_cnt_d = col_cnt_q + CW'(1);
                    if (col_cnt_q + CW'(1) == num_cols_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered as a function of the state being entered.
        col_ready_d = (state_d == ST_ACC) || (state_d == ST_DRAIN);
        out_valid_d = (state_d == ST_EMIT);
        out_mask_d  = (state_d == ST_EMIT) ? active_d : '0;
        busy_d      = (state_d == ST_CLEAR) || (state_d == ST_ACC) ||
                      (state_d == ST_EMIT)  || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
        ctrl_d      = (state_d == ST_CLEAR) ? clear_word : '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            num_cols_q  <= '0;
            col_cnt_q   <= '0;
            win_col_q   <= '0;
            active_q    <= '0;
            use_q       <= '0;
            ctrl_q      <= '0;
            col_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            num_cols_q  <= num_cols_d;
            col_cnt_q   <= col_cnt_d;
            win_col_q   <= win_col_d;
            active_q    <= active_d;
            use_q       <= use_d;
            ctrl_q      <= ctrl_d;
            col_ready_q <= col_ready_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // In ACC the write bit follows colValid directly so it is already settled
    // by the negedge at which the ALUs capture.
    assign bus.controlBus = ctrl_q |
                            (((state_q == ST_ACC) && bus.colValid) ? acc_word : '0);
    assign bus.colReady   = col_ready_q;
    assign bus.outValid   = out_valid_q;
    assign bus.outRowMask = out_mask_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfgErr     = cfg_err_q;

endmodule
